// File: rtl/mips_fetch_unit.sv
// Instruction-fetch front end: PC generator, single-outstanding imem handshake, {pc, inst} queue.
// Define FETCH_TRACE_EN to print a simulation trace of pushes and redirects.
module mips_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst_b,
  output logic                         imem_req,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic                         imem_valid,
  input  logic [31:0]                  imem_rdata,
  output logic                         inst_valid,
  output logic [31:0]                  inst,
  output logic [ADDR_W-1:0]            inst_pc,
  input  logic                         inst_ready,
  input  logic                         redirect,
  input  logic [ADDR_W-1:0]            redirect_pc,
  input  logic                         halt,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_q, pend_d;
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [31:0]       q_inst [DEPTH];
  logic [PW-1:0]     rd_q, wr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              push, pop;
  logic [ADDR_W-1:0] redir_pc;

  assign redir_pc   = redirect_pc & ~ADDR_W'(3);
  assign inst_valid = (count_q != '0);
  // Redirect outranks both queue operations in the same cycle.
  assign pop        = inst_valid & inst_ready & ~redirect;
  assign push       = (state_q == StReq) & imem_valid & ~redirect;

  assign imem_req   = (state_q != StIdle);
  assign imem_addr  = pc_q;
  assign inst       = inst_valid ? q_inst[rd_q] : '0;
  assign inst_pc    = inst_valid ? q_pc[rd_q]   : '0;
  assign count      = count_q;

  always_comb begin
    count_d = count_q;
    if (redirect) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    unique case (state_q)
      StIdle: begin
        if (redirect) begin
          pc_d = redir_pc;
          if (!halt) state_d = StReq;
        end else if (!halt && (count_q < DepthC)) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (redirect) begin
          if (imem_valid) begin
            pc_d    = redir_pc;
            state_d = halt ? StIdle : StReq;
          end else begin
            // Request still in flight: keep its address on the bus, remember the target.
            pend_d  = redir_pc;
            state_d = StDrop;
          end
        end else if (imem_valid) begin
          pc_d    = pc_q + ADDR_W'(4);
          state_d = (!halt && (count_d < DepthC)) ? StReq : StIdle;
        end
      end
      StDrop: begin
        if (imem_valid) begin
          pc_d    = redirect ? redir_pc : pend_q;
          state_d = halt ? StIdle : StReq;
        end else if (redirect) begin
          pend_d  = redir_pc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      pend_q  <= RESET_PC;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      count_q <= count_d;
      if (redirect) begin
        rd_q <= '0;
        wr_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + PW'(1);
        if (pop)  rd_q <= rd_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_q]   <= pc_q;
      q_inst[wr_q] <= imem_rdata;
    end
  end

`ifdef FETCH_TRACE_EN
  always @(posedge clk) begin
    if (rst_b && push)     $display("fetch pc=%h inst=%h", pc_q, imem_rdata);
    if (rst_b && redirect) $display("redirect %h", redirect_pc);
  end
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: directed scenarios then random traffic, checked against a
// queue-level model of fetched {pc, inst} pairs and a variable-latency memory responder.
module tb_mips_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic        clk;
  logic        rst_b;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [2:0]  count;

  int          n_pass = 0;
  int          n_fail = 0;
  ent_t        mq[$];
  logic [31:0] exp_pc;
  bit          taint;
  bit          mem_busy;
  int          mem_left;
  int          mem_lat;
  logic [31:0] mem_addr;
  bit          last_fire;

  mips_fetch_unit #(
    .ADDR_W  (32),
    .DEPTH   (4),
    .RESET_PC(32'h0000_0400)
  ) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt       (halt),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs, answer memory, advance the model, cross the edge.
  task automatic tick();
    bit fire;
    bit popm;
    chk("count", 32'(count), 32'(mq.size()));
    chk("inst_valid", 32'(inst_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("inst_pc", inst_pc, mq[0].pc);
      chk("inst", inst, mq[0].ins);
    end
    if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_left = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
        mem_addr = imem_addr;
      end else begin
        chk("addr_stable", imem_addr, mem_addr);
      end
    end
    fire       = imem_req && mem_busy && (mem_left == 0);
    imem_valid = fire;
    imem_rdata = fire ? (imem_addr ^ 32'hA5A5_A5A5) : $urandom();
    last_fire  = fire;
    popm       = (mq.size() != 0) && inst_ready && !redirect;
    if (redirect) begin
      mq.delete();
      taint  = imem_req && !fire;
      exp_pc = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (popm) void'(mq.pop_front());
      if (fire) begin
        if (taint) begin
          taint = 1'b0;
        end else begin
          chk("fetch_addr", imem_addr, exp_pc);
          chk("no_overflow", 32'(mq.size() < 4), 32'd1);
          mq.push_back('{pc: exp_pc, ins: exp_pc ^ 32'hA5A5_A5A5});
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    if (fire) mem_busy = 1'b0;
    else if (mem_busy && mem_left > 0) mem_left--;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] saved;
    bit          got;
    int          k;

    rst_b       = 1'b0;
    imem_valid  = 1'b0;
    imem_rdata  = '0;
    inst_ready  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    halt        = 1'b0;
    exp_pc      = 32'h400;
    taint       = 1'b0;
    mem_busy    = 1'b0;
    mem_left    = 0;
    mem_lat     = 0;
    mem_addr    = '0;
    last_fire   = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h400);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_count", 32'(count), 32'd0);

    rst_b = 1'b1;
    tick();
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h400);

    // Zero-wait streaming, one instruction per cycle
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stream_pc", inst_pc, 32'h400 + 32'(4 * i));
      chk("stream_inst", inst, (32'h400 + 32'(4 * i)) ^ 32'hA5A5_A5A5);
    end

    // Fill the queue, then drain it in order
    inst_ready  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h400;
    tick();
    redirect = 1'b0;
    repeat (4) tick();
    chk("full_count", 32'(count), 32'd4);
    chk("full_req", 32'(imem_req), 32'd0);
    tick();
    chk("full_hold_req", 32'(imem_req), 32'd0);
    inst_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", inst_pc, 32'h400 + 32'(4 * i));
      if (imem_req && !got) begin
        got = 1'b1;
        chk("resume_addr", imem_addr, 32'h410);
      end
      tick();
    end
    chk("resume_seen", 32'(got), 32'd1);

    // 3-cycle memory, redirect one cycle into a request
    halt = 1'b1;
    for (k = 0; k < 50; k++) begin
      if (!imem_req && mq.size() == 0) break;
      tick();
    end
    chk("drain_done", 32'(k < 50), 32'd1);
    halt    = 1'b0;
    mem_lat = 3;
    saved   = exp_pc;
    tick();
    chk("lat_req", 32'(imem_req), 32'd1);
    chk("lat_addr", imem_addr, saved);
    redirect    = 1'b1;
    redirect_pc = 32'h1000;
    tick();
    redirect = 1'b0;
    chk("drop_req", 32'(imem_req), 32'd1);
    chk("drop_addr_hold", imem_addr, saved);
    got = 1'b0;
    for (k = 0; k < 30; k++) begin
      if (mq.size() != 0) break;
      if (imem_req && imem_addr !== saved && !got) begin
        got = 1'b1;
        chk("redir_addr", imem_addr, 32'h1000);
      end
      tick();
    end
    chk("redir_seen", 32'(got), 32'd1);
    chk("redir_head", inst_pc, 32'h1000);

    // Redirect with valid and ready in the same cycle, count=2
    mem_lat    = 0;
    inst_ready = 1'b0;
    for (k = 0; k < 30; k++) begin
      if (imem_req && mq.size() == 2 && (!mem_busy || mem_left == 0)) break;
      tick();
    end
    chk("cnt2_reached", 32'(k < 30), 32'd1);
    chk("cnt2_count", 32'(count), 32'd2);
    redirect    = 1'b1;
    redirect_pc = 32'h2003;
    inst_ready  = 1'b1;
    tick();
    redirect = 1'b0;
    chk("rv_fired", 32'(last_fire), 32'd1);
    chk("rv_count", 32'(count), 32'd0);
    chk("rv_valid", 32'(inst_valid), 32'd0);
    chk("rv_req", 32'(imem_req), 32'd1);
    chk("rv_addr", imem_addr, 32'h2000);

    // Address wrap, then halt with a request in flight
    inst_ready  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    repeat (2) tick();
    chk("wrap_count", 32'(count), 32'd2);
    chk("wrap_head", inst_pc, 32'hFFFF_FFFC);
    chk("wrap_inst", inst, 32'hFFFF_FFFC ^ 32'hA5A5_A5A5);
    inst_ready = 1'b1;
    tick();
    chk("wrap_zero", inst_pc, 32'h0);
    inst_ready = 1'b0;
    halt       = 1'b1;
    mem_lat    = 2;
    for (k = 0; k < 10; k++) begin
      if (!imem_req) break;
      tick();
    end
    chk("halt_stop", 32'(imem_req), 32'd0);
    chk("halt_one_push", 32'(count), 32'd3);
    repeat (3) tick();
    chk("halt_hold_req", 32'(imem_req), 32'd0);
    chk("halt_hold_cnt", 32'(count), 32'd3);
    halt = 1'b0;
    tick();
    chk("unhalt_req", 32'(imem_req), 32'd1);
    chk("unhalt_addr", imem_addr, 32'hC);

    // Random traffic against the model
    mem_lat = -1;
    for (int i = 0; i < 400; i++) begin
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom();
      inst_ready  = ($urandom_range(0, 2) != 0);
      halt        = ($urandom_range(0, 7) == 0);
      tick();
    end
    redirect = 1'b0;
    halt     = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

- Parametrised instruction-fetch front end for the MIPS core.
- Replaces the core's single PC register and combinational instruction input with three things:
  - a PC generator;
  - a request/valid handshake to an instruction memory of arbitrary latency;
  - a DEPTH-entry prefetch queue of {pc, inst} pairs.
- Branch/jump redirects from the execute stage flush the queue and discard in-flight fetches. Back-pressure from decode stalls fetching.
- Sits between instruction memory/cache and the core's decode/control path.

## Interface
- ADDR_W, 32, PC and instruction-address width.
- DEPTH, 4, prefetch queue entries; power of two, ≥2.
- RESET_PC, 0, first fetch address after reset; word aligned.

- clk  in  1  clock; all state updates on posedge.
- rst_b  in  1  reset, asynchronous, active-low.
- imem_req  out  1  fetch request outstanding.
- imem_addr  out  ADDR_W  address of outstanding request; stable while imem_req=1.
- imem_valid  in  1  response; completes the outstanding request at the sampling edge.
- imem_rdata  in  32  instruction word; valid with imem_valid.
- inst_valid  out  1  queue non-empty.
- inst  out  32  head-of-queue instruction.
- inst_pc  out  ADDR_W  head-of-queue PC.
- inst_ready  in  1  decode accepts head; pop when inst_valid & inst_ready.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  ADDR_W  new fetch address; bits [1:0] ignored, treated as 0.
- halt  in  1  suppress new requests; an in-flight request still completes.
- count  out  $clog2(DEPTH+1)  current queue occupancy.

## Operation
- States:
  - IDLE: imem_req=0.
  - REQ: imem_req=1; response data is kept.
  - DROP: imem_req=1; response data is discarded.
- Memory protocol:
  - At most one outstanding request.
  - imem_req and imem_addr are held until a cycle with imem_valid=1.
  - imem_valid is ignored while imem_req=0.
- IDLE → REQ when halt=0 and count<DEPTH. imem_addr = fetch PC.
- REQ with imem_valid=1 and no redirect:
  - Push {imem_addr, imem_rdata}.
  - PC advances by 4, modulo 2^ADDR_W (0xFFFFFFFC → 0x0).
  - Stay in REQ if halt=0 and the post-edge count<DEPTH; otherwise go to IDLE.
- Queue overflow cannot occur: a request is issued only when count<DEPTH, and only pops can happen before it returns.
- Redirect has priority over push and pop; any pop in that cycle is ignored:
  - Queue is emptied (count=0).
  - In REQ with imem_valid=1: data dropped; next state is REQ at redirect_pc, or IDLE if halt=1.
  - In REQ with imem_valid=0: go to DROP; redirect_pc is latched as pending PC; imem_addr holds the old address.
  - In DROP: pending PC is overwritten by the newest redirect; state stays DROP.
  - In IDLE: PC = redirect_pc; next state is REQ if halt=0.
- DROP with imem_valid=1: data discarded; go to REQ at pending PC, or IDLE if halt=1.
- Simultaneous push and pop: count unchanged; ordering preserved (circular buffer, wrap at DEPTH).

## Timing
- Reset values:
  - Outputs: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, count=0.
  - Internal: state IDLE, fetch PC=RESET_PC.
- First cycle after rst_b deassert: imem_req=1, imem_addr=RESET_PC.
- Zero-wait memory (imem_valid in the same cycle as imem_req) with inst_ready=1 sustains 1 instruction/cycle.
- Push-to-head latency: an instruction pushed at edge N shows inst_valid=1 in cycle N+1 when the queue was empty. inst and inst_pc are driven combinationally from the head entry.
- A full queue costs one IDLE bubble cycle after the first pop before the next request.
- inst_valid=0 in the cycle after a redirect edge.
- Reset during DROP or REQ abandons the request immediately. The memory must be reset concurrently.

## Configuration
- FETCH_TRACE_EN defined:
  - At every push, $display "fetch pc=%h inst=%h".
  - At every redirect, $display "redirect %h".
- Not defined: no simulation output. RTL function is identical either way.

## Test plan
- Reset with RESET_PC=0x400 → all outputs at reset values. After release: imem_req=1, imem_addr=0x400.
- Zero-wait memory returning rdata=addr^0xA5A5A5A5, inst_ready=1 → inst_pc 0x400, 0x404, 0x408 on consecutive cycles, with matching inst values.
- inst_ready=0, DEPTH=4 → count reaches 4 and imem_req drops. Then inst_ready=1 → heads 0x400..0x40C pop in order and imem_addr resumes at 0x410.
- 3-cycle memory latency, redirect to 0x1000 one cycle after a request starts → state DROP, that response is discarded, next imem_addr=0x1000, first inst_pc=0x1000.
- Redirect, imem_valid and inst_ready all high in one cycle with count=2 → nothing pushed, count=0 next cycle, next imem_addr=redirect_pc.
- RESET_PC=0xFFFFFFFC → fetches 0xFFFFFFFC then 0x0. With halt=1 and a request in flight → one push, then imem_req=0.
